// File: rtl/score_sched_if.sv
// Score sequencer bus: game-logic events in, BCD score / status out.
// master = game logic side driving events; slave = score_sched.
// hiscore digits are always present; they read 0 when the high-score feature is off.
interface score_sched_if;
  logic       gamestart;
  logic       shot_enm;
  logic       shot_boss;
  logic       shot_reimu;
  logic [3:0] enm_dead;
  logic       boss_dead;
  logic [3:0] score0;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [3:0] score3;
  logic       busy;
  logic       ev_drop;
  logic [3:0] hiscore0;
  logic [3:0] hiscore1;
  logic [3:0] hiscore2;
  logic [3:0] hiscore3;

  modport master (
    output gamestart, shot_enm, shot_boss, shot_reimu, enm_dead, boss_dead,
    input  score0, score1, score2, score3, busy, ev_drop,
    input  hiscore0, hiscore1, hiscore2, hiscore3
  );

  modport slave (
    input  gamestart, shot_enm, shot_boss, shot_reimu, enm_dead, boss_dead,
    output score0, score1, score2, score3, busy, ev_drop,
    output hiscore0, hiscore1, hiscore2, hiscore3
  );
endinterface

// File: rtl/score_sched.sv
// Score sequencer: queues per-source scoring events, applies them one at a time via a digit-serial BCD add/carry FSM.
// Latency: event sampled E0, granted E1, no-carry result after E2; each carry ripple adds one cycle.
// No backpressure: per-source counters saturate, overflowing events are dropped and flagged on ev_drop.
// Optional high-score register enabled by defining SCORE_HISCORE_EN.
module score_sched #(
  parameter int PEND_W     = 2,
  parameter int HIT_ENM_W  = 1,
  parameter int HIT_BOSS_W = 2
) (
  input  logic         clk22,
  input  logic         rst,
  score_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ADD, CARRY} state_t;

  localparam int                 NSRC     = 7;  // 0=KB, 1..4=K0..K3, 5=HB, 6=HE
  localparam logic [PEND_W-1:0]  PEND_ONE = {{(PEND_W-1){1'b0}}, 1'b1};

  state_t                        state_q, state_d;
  logic [3:0][3:0]               dig_q, dig_d;
  logic [NSRC-1:0][PEND_W-1:0]   pend_q, pend_d;
  logic [1:0]                    idx_q, idx_d;
  logic [3:0]                    addend_q, addend_d;
  logic                          boss_dead_q, boss_dead_d;
  logic [3:0]                    enm_dead_q, enm_dead_d;
  logic                          ev_drop_q, ev_drop_d;
  logic [NSRC-1:0]               ev;
  logic [NSRC-1:0]               gnt;
  logic                          gnt_vld;
  logic [2:0]                    gnt_sel;
  logic [4:0]                    sum;
  logic [4:0]                    sum_m10;
  logic                          carry;
  logic                          flush;

  // Flush on gamestart or player hit: score, queue and FSM all cleared.
  assign flush = bus.gamestart | bus.shot_reimu;

  // Event detection: dead levels become single events on their rising edge.
  always_comb begin
    ev      = '0;
    ev[0]   = bus.boss_dead & ~boss_dead_q;
    ev[4:1] = bus.enm_dead & ~enm_dead_q;
    ev[5]   = bus.shot_boss;
    ev[6]   = bus.shot_enm;
  end

  // Fixed-priority grant in IDLE: lowest source index wins.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    gnt_sel = '0;
    if (state_q == IDLE) begin
      for (int i = 0; i < NSRC; i++) begin
        if (!gnt_vld && pend_q[i] != '0) begin
          gnt_vld = 1'b1;
          gnt_sel = 3'(i);
          gnt[i]  = 1'b1;
        end
      end
    end
  end

  // Digit adder: ADD uses the latched addend, CARRY adds one.
  always_comb begin
    sum     = {1'b0, dig_q[idx_q]} + ((state_q == ADD) ? {1'b0, addend_q} : 5'd1);
    sum_m10 = sum - 5'd10;
    carry   = (sum > 5'd9);
  end

  // State register plus all datapath flops; hiscore is only cleared by rst.
  always_ff @(posedge clk22) begin
    if (rst) begin
      state_q     <= IDLE;
      dig_q       <= '0;
      pend_q      <= '0;
      idx_q       <= '0;
      addend_q    <= '0;
      boss_dead_q <= 1'b0;
      enm_dead_q  <= '0;
      ev_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dig_q       <= dig_d;
      pend_q      <= pend_d;
      idx_q       <= idx_d;
      addend_q    <= addend_d;
      boss_dead_q <= boss_dead_d;
      enm_dead_q  <= enm_dead_d;
      ev_drop_q   <= ev_drop_d;
    end
  end

  // Next-state: ADD/CARRY continue only while a carry ripples below digit3.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld) state_d = ADD;
      ADD:     state_d = (carry && idx_q != 2'd3) ? CARRY : IDLE;
      CARRY:   state_d = (carry && idx_q != 2'd3) ? CARRY : IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Datapath next values: pending counters, grant latch, digit update, flush.
  always_comb begin
    dig_d       = dig_q;
    pend_d      = pend_q;
    idx_d       = idx_q;
    addend_d    = addend_q;
    ev_drop_d   = 1'b0;
    boss_dead_d = bus.gamestart ? 1'b0 : bus.boss_dead;
    enm_dead_d  = bus.gamestart ? 4'd0 : bus.enm_dead;

    // Event and grant on the same counter cancel; a saturated counter drops the event.
    for (int i = 0; i < NSRC; i++) begin
      if (ev[i] && !gnt[i]) begin
        if (&pend_q[i]) ev_drop_d = 1'b1;
        else            pend_d[i] = pend_q[i] + PEND_ONE;
      end else if (gnt[i] && !ev[i]) begin
        pend_d[i] = pend_q[i] - PEND_ONE;
      end
    end

    if (gnt_vld) begin
      if (gnt_sel == 3'd0) begin
        idx_d    = 2'd3;
        addend_d = 4'd1;
      end else if (gnt_sel <= 3'd4) begin
        idx_d    = 2'd2;
        addend_d = 4'd1;
      end else if (gnt_sel == 3'd5) begin
        idx_d    = 2'd0;
        addend_d = 4'(HIT_BOSS_W);
      end else begin
        idx_d    = 2'd0;
        addend_d = 4'(HIT_ENM_W);
      end
    end

    if (state_q == ADD || state_q == CARRY) begin
      if (carry) begin
        if (idx_q == 2'd3) begin
          dig_d = {4{4'd9}};  // carry out of thousands: pin at 9999
        end else begin
          dig_d[idx_q] = sum_m10[3:0];
          idx_d        = idx_q + 2'd1;
        end
      end else begin
        dig_d[idx_q] = sum[3:0];
      end
    end

    if (flush) begin
      dig_d     = '0;
      pend_d    = '0;
      ev_drop_d = 1'b0;
    end
  end

  // Outputs: busy while the FSM works or anything is queued.
  always_comb begin
    bus.busy    = (state_q != IDLE) || (|pend_q);
    bus.ev_drop = ev_drop_q;
    bus.score0  = dig_q[0];
    bus.score1  = dig_q[1];
    bus.score2  = dig_q[2];
    bus.score3  = dig_q[3];
  end

`ifdef SCORE_HISCORE_EN
  logic [3:0][3:0] hiscore_q, hiscore_d;

  // Packed BCD with thousands in the top nibble compares correctly as unsigned.
  always_comb begin
    hiscore_d = hiscore_q;
    if (state_q == IDLE && dig_q > hiscore_q) hiscore_d = dig_q;
  end

  // High score register survives gamestart and player hits.
  always_ff @(posedge clk22) begin
    if (rst) hiscore_q <= '0;
    else     hiscore_q <= hiscore_d;
  end

  // Drive high-score digits from the register.
  always_comb begin
    bus.hiscore0 = hiscore_q[0];
    bus.hiscore1 = hiscore_q[1];
    bus.hiscore2 = hiscore_q[2];
    bus.hiscore3 = hiscore_q[3];
  end
`else
  // High score disabled: digits read as zero.
  always_comb begin
    bus.hiscore0 = 4'd0;
    bus.hiscore1 = 4'd0;
    bus.hiscore2 = 4'd0;
    bus.hiscore3 = 4'd0;
  end
`endif

endmodule

// File: tb/tb_score_sched.sv
// Directed bench for score_sched with a decimal reference model and a queue of expected scores.
// Inputs are driven and outputs sampled on the falling edge of clk22.
// Hiscore expectations follow SCORE_HISCORE_EN when the bench is compiled with it.
module tb_score_sched;
  logic clk22 = 1'b0;
  logic rst;
  always #5 clk22 = ~clk22;

  score_sched_if bus();
  score_sched dut (.clk22(clk22), .rst(rst), .bus(bus));

  int tests  = 0;
  int fails  = 0;
  int model  = 0;
  int hi_exp = 0;
  int exp_q[$];
  int drops;

  function automatic int sc();
    return int'(bus.score3) * 1000 + int'(bus.score2) * 100 + int'(bus.score1) * 10 + int'(bus.score0);
  endfunction

  function automatic int hs();
    return int'(bus.hiscore3) * 1000 + int'(bus.hiscore2) * 100 + int'(bus.hiscore1) * 10 + int'(bus.hiscore0);
  endfunction

  function automatic int sat_add(input int s, input int a);
    return (s + a > 9999) ? 9999 : s + a;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic note_hi();
`ifdef SCORE_HISCORE_EN
    if (model > hi_exp) hi_exp = model;
`endif
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin
      @(negedge clk22);
      n++;
    end
    chk({tag, "_idle"}, int'(bus.busy), 0);
  endtask

  task automatic pop_chk(input string tag);
    int e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    chk(tag, sc(), e);
    note_hi();
  endtask

  task automatic chk_hi(input string tag);
    @(negedge clk22);
    chk(tag, hs(), hi_exp);
  endtask

  // kind: 0 enemy hit (+1), 1 boss hit (+2), 2 enemy k killed (+100), 3 boss killed (+1000)
  task automatic apply(input int kind, input int k);
    int amt;
    @(negedge clk22);
    case (kind)
      0: begin bus.shot_enm = 1'b1;    amt = 1;    end
      1: begin bus.shot_boss = 1'b1;   amt = 2;    end
      2: begin bus.enm_dead[k] = 1'b1; amt = 100;  end
      default: begin bus.boss_dead = 1'b1; amt = 1000; end
    endcase
    model = sat_add(model, amt);
    exp_q.push_back(model);
    @(negedge clk22);
    bus.shot_enm  = 1'b0;
    bus.shot_boss = 1'b0;
    wait_idle($sformatf("ev%0d", kind));
    bus.enm_dead  = 4'd0;
    bus.boss_dead = 1'b0;
    pop_chk($sformatf("ev%0d_score", kind));
  endtask

  task automatic do_gs(input string tag);
    @(negedge clk22);
    bus.gamestart = 1'b1;
    @(negedge clk22);
    bus.gamestart = 1'b0;
    model = 0;
    chk({tag, "_score"}, sc(), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.gamestart  = 1'b0;
    bus.shot_enm   = 1'b0;
    bus.shot_boss  = 1'b0;
    bus.shot_reimu = 1'b0;
    bus.enm_dead   = 4'd0;
    bus.boss_dead  = 1'b0;
    repeat (3) @(negedge clk22);
    chk("rst_score", sc(), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_drop", int'(bus.ev_drop), 0);
    chk("rst_hi", hs(), 0);
    rst = 1'b0;

    // Three enemy hits spaced 4 cycles; idle 2 cycles after each pulse.
    for (int p = 0; p < 3; p++) begin
      @(negedge clk22);
      bus.shot_enm = 1'b1;
      model++;
      exp_q.push_back(model);
      @(negedge clk22);
      bus.shot_enm = 1'b0;
      chk("hit_busy_hi", int'(bus.busy), 1);
      @(negedge clk22);
      @(negedge clk22);
      chk("hit_busy_lo", int'(bus.busy), 0);
      pop_chk("hit_score");
    end

    // 0009 + boss hit: digit0 becomes 1 after ADD, 0011 after CARRY.
    for (int i = 0; i < 6; i++) apply(0, 0);
    chk("pre_carry", sc(), 9);
    @(negedge clk22);
    bus.shot_boss = 1'b1;
    model = sat_add(model, 2);
    exp_q.push_back(model);
    @(negedge clk22);
    bus.shot_boss = 1'b0;
    @(negedge clk22);
    @(negedge clk22);
    chk("add_d0", int'(bus.score0), 1);
    chk("add_d1", int'(bus.score1), 0);
    @(negedge clk22);
    pop_chk("carry_score");
    chk("carry_busy", int'(bus.busy), 0);
    chk_hi("hi_after_11");

    // All enemies and the boss die together: KB, then K0..K3, two cycles each.
    do_gs("gs1");
    chk_hi("hi_gs1");
    @(negedge clk22);
    bus.enm_dead  = 4'hF;
    bus.boss_dead = 1'b1;
    for (int k = 0; k < 5; k++) exp_q.push_back(1000 + 100 * k);
    model = 1400;
    @(negedge clk22);
    for (int k = 0; k < 5; k++) begin
      repeat (2) @(negedge clk22);
      pop_chk($sformatf("kill_step%0d", k));
    end
    chk("kill_busy", int'(bus.busy), 0);
    repeat (4) @(negedge clk22);
    chk("kill_no_recount", sc(), 1400);
    bus.enm_dead  = 4'd0;
    bus.boss_dead = 1'b0;
    chk_hi("hi_1400");

    // Build 0999, then five back-to-back enemy hits during a 3-digit carry chain.
    do_gs("gs2");
    for (int i = 0; i < 9; i++) apply(2, i % 4);
    for (int i = 0; i < 49; i++) apply(1, 0);
    apply(0, 0);
    chk("pre_sat", sc(), 999);
    @(negedge clk22);
    bus.shot_enm = 1'b1;
    model = 1003;
    exp_q.push_back(model);
    drops = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk22);
      drops += int'(bus.ev_drop);
    end
    @(negedge clk22);
    bus.shot_enm = 1'b0;
    chk("drop_at_sat", int'(bus.ev_drop), 1);
    drops += int'(bus.ev_drop);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk22);
      drops += int'(bus.ev_drop);
    end
    chk("drop_count", drops, 1);
    wait_idle("sat");
    pop_chk("sat_score");

    // Player hit while the FSM sits in CARRY with another event queued.
    for (int i = 0; i < 3; i++) apply(1, 0);
    chk("pre_reimu", sc(), 1009);
    @(negedge clk22);
    bus.shot_boss = 1'b1;
    @(negedge clk22);
    bus.shot_boss = 1'b0;
    @(negedge clk22);
    bus.shot_enm = 1'b1;
    @(negedge clk22);
    bus.shot_enm   = 1'b0;
    bus.shot_reimu = 1'b1;
    model = 0;
    exp_q.push_back(model);
    @(negedge clk22);
    bus.shot_reimu = 1'b0;
    pop_chk("reimu_score");
    chk("reimu_busy", int'(bus.busy), 0);
    @(negedge clk22);
    chk("reimu_busy_hold", int'(bus.busy), 0);
    chk("reimu_score_hold", sc(), 0);
    chk_hi("hi_after_reimu");

    // Build 9998, then two boss hits saturate at 9999.
    do_gs("gs3");
    for (int i = 0; i < 9; i++) apply(3, 0);
    for (int i = 0; i < 9; i++) apply(2, i % 4);
    for (int i = 0; i < 49; i++) apply(1, 0);
    chk("pre_9999", sc(), 9998);
    apply(1, 0);
    apply(1, 0);
    chk("sat_9999", sc(), 9999);
    chk_hi("hi_9999");
    do_gs("gs4");
    chk_hi("hi_kept_gs");

    // rst clears the high score too.
    @(negedge clk22);
    rst = 1'b1;
    @(negedge clk22);
    rst = 1'b0;
    hi_exp = 0;
    model  = 0;
    chk("rst2_score", sc(), 0);
    chk("rst2_hi", hs(), hi_exp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
